// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-memory stage.
//  - load_funct3_t / store_funct3_t: RISC-V load/store funct3 encodings,
//    including the RV64 forms ld, lwu and sd.
//  - mem_state_t: memory-stage handshake states.
//  - access_size(): log2 of the access width in bytes, taken from funct3.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010,
        SD = 3'b011
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    // No load or store uses this encoding at any XLEN.
    localparam logic [2:0] FUNCT3_RSVD = 3'b111;

    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the memory stage (purely combinational).
//  write       in   1=store, 0=load
//  funct3      in   load/store funct3
//  offset      in   byte offset inside the XLEN word (addr[log2(XLEN/8)-1:0])
//  wdata       in   store source (rs2)
//  rdata       in   raw cache word
//  store_data  out  store data shifted to its byte lanes
//  store_be    out  byte enables for the store
//  load_data   out  selected and sign/zero-extended load result
//  misaligned  out  access is misaligned or its funct3 is illegal for this XLEN
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB  = XLEN / 8,
    localparam int OW  = $clog2(XLEN / 8)
) (
    input  logic            write,
    input  logic [2:0]      funct3,
    input  logic [OW-1:0]   offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] store_data,
    output logic [NB-1:0]   store_be,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned
);

    logic [1:0]      size;
    int              nbytes;
    int              shamt;
    logic [OW-1:0]   off_mask;
    logic [XLEN-1:0] lane_mask;
    logic [NB-1:0]   byte_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] tmp;

    always_comb begin
        size     = access_size(funct3);
        nbytes   = 1 << size;
        off_mask = OW'(nbytes - 1);

        // Illegal encodings share the misaligned exception path.
        // Stores have no unsigned forms, so funct3[2] is illegal for them.
        misaligned = (|(offset & off_mask))
                  || (funct3 == FUNCT3_RSVD)
                  || (write && funct3[2])
                  || ((XLEN == 32) && ((size == 2'd3) || (funct3 == LWU)));

        if (nbytes >= NB) begin
            lane_mask = '1;
            byte_mask = '1;
        end else begin
            lane_mask = (XLEN'(1) << (8 * nbytes)) - XLEN'(1);
            byte_mask = NB'((1 << nbytes) - 1);
        end

        store_data = (wdata & lane_mask) << {offset, 3'b000};
        store_be   = byte_mask << offset;

        // Move the addressed lane to bit 0, park its MSB at the top of the
        // word, then shift back down: logical shift zero-extends, arithmetic
        // shift sign-extends. Works for any access width up to XLEN.
        shifted = rdata >> {offset, 3'b000};
        shamt   = (nbytes >= NB) ? 0 : XLEN - 8 * nbytes;
        tmp     = shifted << shamt;
        if (funct3[2]) begin
            load_data = tmp >> shamt;
        end else begin
            load_data = $signed(tmp) >>> shamt;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: aligns loads/stores, runs the request/response
// handshake with a multi-cycle data cache and stalls the pipeline meanwhile.
//  clk, rst           clock, synchronous active-high reset
//  req_*              load/store from EX/MEM (valid, write, funct3, addr, wdata)
//  flush              squash the current request
//  mem_*              cache request (read/write/address/wdata/byte_enable),
//                     completion pulse mem_resp with mem_rdata
//  stall              freeze the pipeline this cycle
//  rsp_valid/rdata    completed access and its extended load result
//  exc_misaligned     request rejected (misaligned or illegal funct3)
//  exc_timeout        request aborted after TIMEOUT cycles without response
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              flush,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byte_enable,
    input  logic              mem_resp,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              exc_misaligned,
    output logic              exc_timeout
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mem_state_t      state, state_next;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [OW-1:0]   offset_q;
    logic [CW-1:0]   count;
    logic            squash;
    logic            in_access;
    logic            timeout_hit;

    logic            al_write;
    logic [2:0]      al_funct3;
    logic [OW-1:0]   al_offset;
    logic [XLEN-1:0] al_store_data;
    logic [NB-1:0]   al_store_be;
    logic [XLEN-1:0] al_load_data;
    logic            al_misaligned;

    // One aligner serves both phases: in IDLE it checks/shifts the incoming
    // request, in ACCESS it extends the response using the latched request.
    assign in_access = (state == ACCESS);
    assign al_write  = in_access ? write_q  : req_write;
    assign al_funct3 = in_access ? funct3_q : req_funct3;
    assign al_offset = in_access ? offset_q : req_addr[OW-1:0];

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .write      (al_write),
        .funct3     (al_funct3),
        .offset     (al_offset),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .store_data (al_store_data),
        .store_be   (al_store_be),
        .load_data  (al_load_data),
        .misaligned (al_misaligned)
    );

    assign timeout_hit = (TIMEOUT != 0) && (count == CNT_LAST);

    always_comb begin
        state_next     = state;
        stall          = 1'b0;
        rsp_valid      = 1'b0;
        exc_misaligned = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (al_misaligned) begin
                        exc_misaligned = 1'b1;
                    end else if (!flush) begin
                        stall      = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                // A response on the timeout edge still completes normally.
                if (mem_resp) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                rsp_valid  = !squash && !flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            rsp_rdata       <= '0;
            exc_timeout     <= 1'b0;
            write_q         <= 1'b0;
            funct3_q        <= '0;
            offset_q        <= '0;
            count           <= '0;
            squash          <= 1'b0;
        end else begin
            state       <= state_next;
            exc_timeout <= 1'b0;
            if (state == IDLE && state_next == ACCESS) begin
                mem_read        <= !req_write;
                mem_write       <= req_write;
                mem_address     <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
                mem_wdata       <= al_store_data;
                mem_byte_enable <= al_store_be;
                write_q         <= req_write;
                funct3_q        <= req_funct3;
                offset_q        <= req_addr[OW-1:0];
                count           <= '0;
                squash          <= 1'b0;
            end
            if (in_access) begin
                count <= count + 1'b1;
                // The cache handshake cannot be abandoned; remember to hide
                // the result instead.
                if (flush) begin
                    squash <= 1'b1;
                end
                if (mem_resp) begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    rsp_rdata <= write_q ? '0 : al_load_data;
                end else if (timeout_hit) begin
                    mem_read    <= 1'b0;
                    mem_write   <= 1'b0;
                    exc_timeout <= 1'b1;
                end
            end
            if (state == DONE) begin
                squash <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: a vector table for the lane/extend/alignment function on
// XLEN=32 (TIMEOUT=4) and XLEN=64 instances, plus hand sequences for
// latency, timeout, flush and reset-in-flight behaviour.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv32 = 1'b0, rv64 = 1'b0;
    logic        req_write = 1'b0, flush = 1'b0, mem_resp = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;

    logic        rd32, wr32, stall32, rsp32, mis32, to32;
    logic [31:0] ma32, mw32, rdat32;
    logic [3:0]  be32;
    logic        rd64, wr64, stall64, rsp64, mis64, to64;
    logic [63:0] ma64, mw64, rdat64;
    logic [7:0]  be64;

    bit          cur64 = 1'b0;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .req_valid(rv32), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .flush(flush), .mem_read(rd32), .mem_write(wr32), .mem_address(ma32),
        .mem_wdata(mw32), .mem_byte_enable(be32), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata[31:0]), .stall(stall32), .rsp_valid(rsp32),
        .rsp_rdata(rdat32), .exc_misaligned(mis32), .exc_timeout(to32)
    );

    mem_access_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .req_valid(rv64), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush(flush), .mem_read(rd64), .mem_write(wr64), .mem_address(ma64),
        .mem_wdata(mw64), .mem_byte_enable(be64), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .stall(stall64), .rsp_valid(rsp64),
        .rsp_rdata(rdat64), .exc_misaligned(mis64), .exc_timeout(to64)
    );

    logic        o_rd, o_wr, o_stall, o_rsp, o_mis;
    logic [63:0] o_addr, o_wdata, o_rdata;
    logic [7:0]  o_be;
    assign o_rd    = cur64 ? rd64    : rd32;
    assign o_wr    = cur64 ? wr64    : wr32;
    assign o_stall = cur64 ? stall64 : stall32;
    assign o_rsp   = cur64 ? rsp64   : rsp32;
    assign o_mis   = cur64 ? mis64   : mis32;
    assign o_addr  = cur64 ? ma64    : {32'b0, ma32};
    assign o_wdata = cur64 ? mw64    : {32'b0, mw32};
    assign o_rdata = cur64 ? rdat64  : {32'b0, rdat32};
    assign o_be    = cur64 ? be64    : {4'b0, be32};

    typedef struct {
        bit          x64;
        bit          wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        bit          mis;
        logic [63:0] eaddr;
        logic [63:0] ewdata;
        logic [7:0]  ebe;
        logic [63:0] erdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        cur64 = v.x64;
        @(negedge clk);
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        if (v.x64) rv64 = 1'b1; else rv32 = 1'b1;
        #1;
        chk($sformatf("v%0d exc_misaligned", idx), 64'(o_mis), 64'(v.mis));
        chk($sformatf("v%0d stall_req", idx), 64'(o_stall), 64'(!v.mis));
        @(negedge clk);
        rv32 = 1'b0;
        rv64 = 1'b0;
        #1;
        if (v.mis) begin
            chk($sformatf("v%0d no_access", idx), 64'(o_rd | o_wr), 64'(0));
        end else begin
            chk($sformatf("v%0d mem_read", idx), 64'(o_rd), 64'(!v.wr));
            chk($sformatf("v%0d mem_write", idx), 64'(o_wr), 64'(v.wr));
            chk($sformatf("v%0d mem_address", idx), o_addr, v.eaddr);
            if (v.wr) begin
                chk($sformatf("v%0d mem_wdata", idx), o_wdata, v.ewdata);
                chk($sformatf("v%0d byte_enable", idx), 64'(o_be), 64'(v.ebe));
            end
            mem_resp  = 1'b1;
            mem_rdata = v.rdata;
            @(negedge clk);
            mem_resp = 1'b0;
            #1;
            chk($sformatf("v%0d rsp_valid", idx), 64'(o_rsp), 64'(1));
            chk($sformatf("v%0d rsp_rdata", idx), o_rdata, v.erdata);
            @(negedge clk);
        end
    endtask

    initial begin
        int stall_n, rsp_at, rsp_n, read_n, to_at, to_n;

        //                x64   wr    f3    addr             wdata                  rdata                  mis   eaddr            ewdata                 ebe    erdata
        vecs.push_back('{1'b0, 1'b1, 3'd2, 64'h104,         64'hDEADBEEF,          64'hFFFFFFFF,          1'b0, 64'h104,         64'hDEADBEEF,          8'hF,  64'h0});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 64'h103,         64'h0,                 64'h80FF0000,          1'b0, 64'h100,         64'h0,                 8'h0,  64'hFFFFFF80});
        vecs.push_back('{1'b0, 1'b0, 3'd5, 64'h102,         64'h0,                 64'h80FF0000,          1'b0, 64'h100,         64'h0,                 8'h0,  64'h000080FF});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 64'h102,         64'h1234,              64'hFFFFFFFF,          1'b0, 64'h100,         64'h12340000,          8'hC,  64'h0});
        vecs.push_back('{1'b0, 1'b0, 3'd2, 64'h102,         64'h0,                 64'h0,                 1'b1, 64'h0,           64'h0,                 8'h0,  64'h0});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 64'h101,         64'h123456AB,          64'h0,                 1'b0, 64'h100,         64'h0000AB00,          8'h2,  64'h0});
        vecs.push_back('{1'b0, 1'b0, 3'd1, 64'h102,         64'h0,                 64'h80FF0000,          1'b0, 64'h100,         64'h0,                 8'h0,  64'hFFFF80FF});
        vecs.push_back('{1'b0, 1'b0, 3'd2, 64'h108,         64'h0,                 64'h12345678,          1'b0, 64'h108,         64'h0,                 8'h0,  64'h12345678});
        vecs.push_back('{1'b0, 1'b0, 3'd3, 64'h100,         64'h0,                 64'h0,                 1'b1, 64'h0,           64'h0,                 8'h0,  64'h0});
        vecs.push_back('{1'b0, 1'b0, 3'd7, 64'h100,         64'h0,                 64'h0,                 1'b1, 64'h0,           64'h0,                 8'h0,  64'h0});
        vecs.push_back('{1'b0, 1'b0, 3'd4, 64'h100,         64'h0,                 64'h000000F0,          1'b0, 64'h100,         64'h0,                 8'h0,  64'h000000F0});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 64'h101,         64'h5555,              64'h0,                 1'b1, 64'h0,           64'h0,                 8'h0,  64'h0});
        vecs.push_back('{1'b0, 1'b0, 3'd6, 64'h100,         64'h0,                 64'h0,                 1'b1, 64'h0,           64'h0,                 8'h0,  64'h0});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 64'h1008,        64'h0,                 64'h8000000000000001,  1'b0, 64'h1008,        64'h0,                 8'h0,  64'h8000000000000001});
        vecs.push_back('{1'b1, 1'b0, 3'd6, 64'h100C,        64'h0,                 64'h8000000000000000,  1'b0, 64'h1008,        64'h0,                 8'h0,  64'h0000000080000000});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 64'h100C,        64'h0,                 64'h8000000000000000,  1'b0, 64'h1008,        64'h0,                 8'h0,  64'hFFFFFFFF80000000});
        vecs.push_back('{1'b1, 1'b1, 3'd3, 64'h1010,        64'h0123456789ABCDEF,  64'h0,                 1'b0, 64'h1010,        64'h0123456789ABCDEF,  8'hFF, 64'h0});
        vecs.push_back('{1'b1, 1'b1, 3'd2, 64'h1014,        64'hCAFEF00D,          64'h0,                 1'b0, 64'h1010,        64'hCAFEF00D00000000,  8'hF0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 64'h1004,        64'h0,                 64'h0,                 1'b1, 64'h0,           64'h0,                 8'h0,  64'h0});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 64'h1006,        64'h0,                 64'h8001000000000000,  1'b0, 64'h1000,        64'h0,                 8'h0,  64'hFFFFFFFFFFFF8001});

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset mem_rw", 64'({rd32, wr32, rd64, wr64}), 64'(0));
        chk("reset stall_rsp", 64'({stall32, rsp32, stall64, rsp64}), 64'(0));
        chk("reset exc", 64'({mis32, to32, mis64, to64}), 64'(0));
        chk("reset mem_address", ma64 | {32'b0, ma32}, 64'h0);
        chk("reset rsp_rdata", rdat64 | {32'b0, rdat32}, 64'h0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // sw with the response in the third ACCESS cycle
        cur64 = 1'b0;
        @(negedge clk);
        req_write = 1'b1; req_funct3 = 3'd2; req_addr = 64'h104; req_wdata = 64'hDEADBEEF;
        stall_n = 0; rsp_at = 0; rsp_n = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            rv32     = (c <= 5);
            mem_resp = (c == 4);
            #1;
            if (stall32) stall_n++;
            if (rsp32) begin rsp_at = c; rsp_n++; end
            if (c == 2) chk("lat mem_write", 64'({wr32, rd32, be32}), 64'h2F);
            if (c == 6) chk("lat no_reissue", 64'({wr32, rd32, stall32}), 64'(0));
        end
        mem_resp = 1'b0;
        chk("lat stall_cycles", 64'(stall_n), 64'(4));
        chk("lat rsp_cycle", 64'(rsp_at), 64'(5));
        chk("lat rsp_pulses", 64'(rsp_n), 64'(1));

        // Timeout: lw with no response ever
        @(negedge clk);
        req_write = 1'b0; req_funct3 = 3'd2; req_addr = 64'h200;
        read_n = 0; to_at = 0; to_n = 0; rsp_n = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            rv32 = (c <= 5);
            #1;
            if (rd32) read_n++;
            if (to32) begin to_at = c; to_n++; end
            if (rsp32) rsp_n++;
        end
        chk("to read_cycles", 64'(read_n), 64'(4));
        chk("to exc_cycle", 64'(to_at), 64'(6));
        chk("to exc_pulses", 64'(to_n), 64'(1));
        chk("to idle", 64'({stall32, rsp_n != 0}), 64'(0));

        // Flush one cycle after issue, response two cycles after that
        @(negedge clk);
        req_funct3 = 3'd2; req_addr = 64'h300; mem_rdata = 64'h11223344;
        read_n = 0; rsp_n = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            rv32     = (c == 1);
            flush    = (c == 2);
            mem_resp = (c == 4);
            #1;
            if (rd32) read_n++;
            if (rsp32) rsp_n++;
            if (c == 4) chk("flush stall_held", 64'(stall32), 64'(1));
            if (c == 5) chk("flush done_nostall", 64'({stall32, rd32}), 64'(0));
        end
        chk("flush read_cycles", 64'(read_n), 64'(3));
        chk("flush no_rsp", 64'(rsp_n), 64'(0));

        // Flush arriving in DONE also hides the response
        @(negedge clk);
        rv32 = 1'b1;
        @(negedge clk);
        rv32 = 1'b0; mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0; flush = 1'b1;
        #1;
        chk("flush_done rsp", 64'(rsp32), 64'(0));
        @(negedge clk);
        flush = 1'b0;

        // Reset while waiting in ACCESS, then a late response in IDLE
        @(negedge clk);
        req_addr = 64'h400;
        rv32 = 1'b1;
        @(negedge clk);
        rv32 = 1'b0;
        #1;
        chk("rst pre_read", 64'(rd32), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst read_dropped", 64'(rd32), 64'(0));
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        chk("rst late_resp_ignored", 64'({rsp32, stall32, rd32}), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
